hil_result_collector: RTL and testbench
=======================================

// Module: hil_result_collector
// PURPOSE
// Host-facing capture end of the HIL test path. The stimulus side drives the dataflow top's input ports;
// this block sits on the top's output port (e.g. n6_z). It skips the pipeline fill (delay-line latency),
// packs a fixed number of output samples LSB-first into words, and buffers them in a FIFO.
// The host drains the FIFO over a valid/ready stream.
// PARAMETERS
// DATA_W      1    width of one DUT output sample
// SPW         32   samples per packed word; WORD_W = DATA_W*SPW
// LATENCY     33   valid DUT samples discarded after start (pipeline fill); 0 allowed
// FIFO_DEPTH  16   words of buffering; power of two, >= 2
// COUNT_W     16   width of sample counters
// PORTS
// clock        in   1        sole clock, rising edge
// reset        in   1        asynchronous, active-low (0 = reset)
// start        in   1        one-cycle pulse: begin a capture run
// num_samples  in   COUNT_W  samples to capture; sampled only on an accepted start
// dut_valid    in   1        dut_out holds a valid sample this cycle
// dut_out      in   DATA_W   DUT output sample
// m_valid      out  1        m_data/m_last valid to host
// m_ready      in   1        host accepts the word when m_valid & m_ready
// m_data       out  WORD_W   packed word, sample k at bits [k*DATA_W +: DATA_W]
// m_last       out  1        word is the final word of the run
// busy         out  1        high in any state except IDLE
// done         out  1        one-cycle pulse at end of run
// overflow     out  1        sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
// - Reset: all outputs 0. FSM goes to IDLE. FIFO is emptied. Counters, pack register and overflow are cleared.
//   Reset mid-run aborts the run. No done pulse is produced.
// - FSM IDLE -> FLUSH -> CAPTURE -> DRAIN -> IDLE.
//   - IDLE: a start pulse latches num_samples and clears overflow.
//     If num_samples==0, the FSM goes to DRAIN. Else, if LATENCY==0, it goes to CAPTURE. Otherwise it goes to FLUSH.
//   - FLUSH: each cycle with dut_valid=1 decrements the skip count. After the LATENCY-th valid sample, the FSM
//     goes to CAPTURE. That sample itself is discarded.
//   - CAPTURE: each dut_valid=1 cycle writes dut_out into slot k of the pack register, and k increments.
//     - On k==SPW-1, or on the final sample of the run, the word is pushed to the FIFO the same cycle.
//       Unfilled slots are zero. m_last=1 only on the final word. k is reset to 0.
//     - The FSM goes to DRAIN on the cycle the final sample is taken.
//   - DRAIN: waits for the FIFO to be empty with no handshake pending. It then pulses done for exactly one
//     cycle and goes to IDLE. The done pulse falls in the cycle after the last handshake.
// - start while busy=1 is ignored. dut_valid is ignored in IDLE and DRAIN.
// - Words per run = ceil(num_samples/SPW).
// - FIFO:
//   - A pushed word appears on m_valid the cycle after the push when the FIFO was empty.
//   - m_data and m_last stay stable while m_valid=1 and m_ready=0.
//   - m_valid never drops without a handshake.
//   - A push and a pop in the same cycle are both honoured, including when the FIFO is full.
//   - A push when full without a pop drops the word and sets overflow. The run still completes and done
//     still pulses.
//   - Pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses an extra pointer bit.
// - The host may hold m_ready high continuously. Back-to-back words then drain one per cycle.
// TESTING
// - Reset:
//   - Hold reset=0 while toggling all inputs -> all outputs stay 0.
//   - Release reset -> m_valid stays 0 until a run pushes a word.
// - Basic run:
//   - Set LATENCY=33, SPW=32, DATA_W=1, num_samples=64, m_ready=1.
//   - Drive dut_valid=1 every cycle, with dut_out=0 for the first 33 samples, then pattern 0xA5A5A5A5 twice.
//   - Required: 2 words of 0xA5A5A5A5, m_last on the 2nd, done 1 cycle after the 2nd handshake.
// - Partial word: num_samples=5, samples 1,0,1,1,1 -> one word 0x0000001D with m_last=1.
// - Backpressure:
//   - num_samples=32*20 with m_ready=0 throughout.
//   - Required: the first 16 words are held; overflow rises on the 17th push.
//   - Then set m_ready=1. Required: exactly 16 words drained, the last without m_last, and done pulses.
// - Gaps and ignored start:
//   - Drive dut_valid randomly with 50% duty; pulse start mid-run.
//   - Required: words match the valid-only sample sequence; the second start has no effect.
// - Edge cases:
//   - num_samples=0 -> done pulses within 3 cycles; no m_valid.
//   - LATENCY=0 -> the first valid sample lands in bit 0.
//   - Reset asserted mid-CAPTURE -> no done pulse; the next run is correct.

Source files
------------

// File: rtl/hil_result_collector.sv
// Capture end of the HIL path: skips the pipeline fill, packs DUT output samples
// LSB-first into words and queues them in a FIFO drained by the host over valid/ready.
module hil_result_collector #(
  parameter int DATA_W     = 1,
  parameter int SPW        = 32,
  parameter int LATENCY    = 33,
  parameter int FIFO_DEPTH = 16,
  parameter int COUNT_W    = 16,
  parameter int WORD_W     = DATA_W * SPW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [COUNT_W-1:0] num_samples_i,
  input  logic               dut_valid_i,
  input  logic [DATA_W-1:0]  dut_out_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [WORD_W-1:0]  m_data_o,
  output logic               m_last_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               overflow_o
);

  localparam int SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic [COUNT_W-1:0] LAT_CNT   = COUNT_W'(LATENCY);
  localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(SPW - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [COUNT_W-1:0]  skip_q, skip_d;
  logic [COUNT_W-1:0]  remain_q, remain_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [WORD_W-1:0]   pack_q, pack_d;
  logic                overflow_q, overflow_d;

  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WORD_W:0]     mem_q [FIFO_DEPTH];
  logic [WORD_W:0]     rd_entry;

  logic                fifo_empty, fifo_full;
  logic                push, pop, wr_en;
  logic                push_last;
  logic [WORD_W-1:0]   push_word;
  logic [WORD_W-1:0]   word_w;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign pop        = m_valid_o && m_ready_i;
  // A full FIFO still takes a word when the host frees a slot in the same cycle.
  assign wr_en      = push && (!fifo_full || pop);

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d    = state_q;
    skip_d     = skip_q;
    remain_d   = remain_q;
    slot_d     = slot_q;
    pack_d     = pack_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    push_last  = 1'b0;
    push_word  = '0;
    word_w     = pack_q;
    word_w[int'(slot_q) * DATA_W +: DATA_W] = dut_out_i;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          remain_d   = num_samples_i;
          skip_d     = LAT_CNT;
          slot_d     = '0;
          pack_d     = '0;
          overflow_d = 1'b0;
          if (num_samples_i == '0) begin
            state_d = DRAIN;
          end else if (LATENCY == 0) begin
            state_d = CAPTURE;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (dut_valid_i) begin
          skip_d = skip_q - COUNT_W'(1);
          if (skip_q == COUNT_W'(1)) begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (dut_valid_i) begin
          remain_d = remain_q - COUNT_W'(1);
          if ((remain_q == COUNT_W'(1)) || (slot_q == LAST_SLOT)) begin
            push      = 1'b1;
            push_word = word_w;
            push_last = (remain_q == COUNT_W'(1));
            pack_d    = '0;
            slot_d    = '0;
          end else begin
            pack_d = word_w;
            slot_d = slot_q + SLOT_W'(1);
          end
          if (remain_q == COUNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      skip_q     <= '0;
      remain_q   <= '0;
      slot_q     <= '0;
      pack_q     <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      remain_q   <= remain_d;
      slot_q     <= slot_d;
      pack_q     <= pack_d;
      overflow_q <= overflow_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // NOTE: storage is left unreset; the pointers define what is valid and outputs are gated below.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {push_last, push_word};
    end
  end

  assign rd_entry   = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign m_valid_o  = !fifo_empty;
  assign m_data_o   = m_valid_o ? rd_entry[WORD_W-1:0] : '0;
  assign m_last_o   = m_valid_o && rd_entry[WORD_W];
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DRAIN) && fifo_empty;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_hil_result_collector.sv
// Bench for hil_result_collector: a queue-based model of the capture run checked every
// cycle, plus directed runs with hand-computed words.
module tb_hil_result_collector;

  localparam int LAT   = 33;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic [15:0] num_samples = '0;
  logic        dut_valid = 1'b0;
  logic [0:0]  dut_out = '0;
  logic        m_ready = 1'b0;

  logic        m_valid, m_last, busy, done, overflow;
  logic [31:0] m_data;
  logic        m_valid0, m_last0, busy0, done0, overflow0;
  logic [31:0] m_data0;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  hil_result_collector #(.DATA_W(1), .SPW(32), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .COUNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_samples_i(num_samples),
    .dut_valid_i(dut_valid), .dut_out_i(dut_out), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_last_o(m_last), .busy_o(busy), .done_o(done), .overflow_o(overflow)
  );

  hil_result_collector #(.DATA_W(1), .SPW(32), .LATENCY(0), .FIFO_DEPTH(DEPTH), .COUNT_W(16)) u_dut_lat0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .num_samples_i(num_samples),
    .dut_valid_i(dut_valid), .dut_out_i(dut_out), .m_valid_o(m_valid0), .m_ready_i(m_ready),
    .m_data_o(m_data0), .m_last_o(m_last0), .busy_o(busy0), .done_o(done0), .overflow_o(overflow0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a run discards LAT valid samples, then packs the next n into 32-bit words
  // held in a bounded queue standing in for the FIFO.
  bit          mdl_run;
  bit          mdl_ovf;
  bit          run_pre;
  int          mdl_n, mdl_seen, mdl_taken;
  logic [31:0] mdl_word;
  logic [32:0] mdl_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_run   = 1'b0;
      mdl_ovf   = 1'b0;
      mdl_n     = 0;
      mdl_seen  = 0;
      mdl_taken = 0;
      mdl_word  = '0;
      mdl_q.delete();
    end else begin
      run_pre = mdl_run;
      if (mdl_run && mdl_taken == mdl_n && mdl_q.size() == 0) mdl_run = 1'b0;
      if (mdl_q.size() > 0 && m_ready) void'(mdl_q.pop_front());
      if (!run_pre && start) begin
        mdl_run   = 1'b1;
        mdl_n     = int'(num_samples);
        mdl_seen  = 0;
        mdl_taken = 0;
        mdl_word  = '0;
        mdl_ovf   = 1'b0;
      end else if (run_pre && dut_valid && mdl_taken < mdl_n) begin
        if (mdl_seen < LAT) begin
          mdl_seen++;
        end else begin
          mdl_word[mdl_taken % 32] = dut_out[0];
          mdl_taken++;
          if (mdl_taken % 32 == 0 || mdl_taken == mdl_n) begin
            if (mdl_q.size() < DEPTH) mdl_q.push_back({mdl_taken == mdl_n, mdl_word});
            else mdl_ovf = 1'b1;
            mdl_word = '0;
          end
        end
      end
    end
  end

  int          cyc = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          last_hs_cyc = 0;
  int          done_cyc = 0;
  logic [31:0] hs_data[$];
  bit          hs_last[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    check("m_valid", m_valid, mdl_q.size() > 0);
    if (m_valid && mdl_q.size() > 0) begin
      check("m_data", m_data, mdl_q[0][31:0]);
      check("m_last", m_last, mdl_q[0][32]);
    end
    check("busy", busy, mdl_run);
    check("done", done, mdl_run && mdl_taken == mdl_n && mdl_q.size() == 0);
    check("overflow", overflow, mdl_ovf);
    if (!rst_n) begin
      check("rst_m_data", m_data, 0);
      check("rst_lat0_outputs", {m_valid0, m_data0, m_last0, busy0, done0, overflow0}, 0);
    end
    if (m_valid && m_ready) begin
      hs_cnt++;
      hs_data.push_back(m_data);
      hs_last.push_back(m_last);
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n);
    num_samples = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input bit b);
    dut_valid = 1'b1;
    dut_out = b;
    tick();
    dut_valid = 1'b0;
  endtask

  task automatic flush_fill();
    for (int i = 0; i < LAT; i++) send(1'b0);
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    check(name, done_cnt, d0 + 1);
  endtask

  initial begin
    logic [31:0] pat;
    logic [4:0]  bits5;
    int h0, d0, s_cyc, nv, lasts;
    bit seen0;

    // Reset held while inputs toggle
    #1 rst_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      start = 1'($urandom_range(0, 1));
      start0 = 1'($urandom_range(0, 1));
      dut_valid = 1'($urandom_range(0, 1));
      dut_out = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      num_samples = 16'($urandom_range(0, 100));
      tick();
    end
    start = 1'b0; start0 = 1'b0; dut_valid = 1'b0; m_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("post_reset_idle", {m_valid, busy, overflow}, 0);

    // Basic run: two words of 0xA5A5A5A5
    m_ready = 1'b1;
    pat = 32'hA5A5A5A5;
    h0 = hs_cnt;
    start_run(64);
    flush_fill();
    for (int k = 0; k < 64; k++) send(pat[k % 32]);
    wait_done(20, "basic_done");
    check("basic_words", hs_cnt - h0, 2);
    check("basic_w0", hs_data[h0], 32'hA5A5A5A5);
    check("basic_w1", hs_data[h0 + 1], 32'hA5A5A5A5);
    check("basic_last", {hs_last[h0], hs_last[h0 + 1]}, 2'b01);
    check("basic_done_timing", done_cyc, last_hs_cyc + 1);

    // Partial word: 1,0,1,1,1 -> 0x1D
    h0 = hs_cnt;
    bits5 = 5'b11101;
    start_run(5);
    flush_fill();
    for (int k = 0; k < 5; k++) send(bits5[k]);
    wait_done(20, "partial_done");
    check("partial_words", hs_cnt - h0, 1);
    check("partial_data", hs_data[h0], 32'h0000001D);
    check("partial_last", hs_last[h0], 1);

    // Backpressure: 20 words into a 16-deep FIFO
    m_ready = 1'b0;
    h0 = hs_cnt;
    d0 = done_cnt;
    start_run(32 * 20);
    flush_fill();
    for (int k = 0; k < 32 * 20; k++) send(1'($urandom_range(0, 1)));
    tick();
    check("bp_overflow", overflow, 1);
    check("bp_held", {m_valid, busy}, 2'b11);
    check("bp_no_done_yet", done_cnt, d0);
    m_ready = 1'b1;
    wait_done(40, "bp_done");
    check("bp_words", hs_cnt - h0, 16);
    lasts = 0;
    for (int i = h0; i < hs_cnt; i++) lasts += int'(hs_last[i]);
    check("bp_no_last", lasts, 0);

    // Gaps and a start pulse mid-run
    h0 = hs_cnt;
    start_run(96);
    nv = 0;
    for (int i = 0; i < 2000 && nv < LAT + 96; i++) begin
      dut_valid = 1'($urandom_range(0, 1));
      dut_out = 1'($urandom_range(0, 1));
      if (i == 50) begin
        start = 1'b1;
        num_samples = 16'd7;
      end
      if (dut_valid) nv++;
      tick();
      start = 1'b0;
    end
    dut_valid = 1'b0;
    wait_done(20, "gaps_done");
    check("gaps_words", hs_cnt - h0, 3);
    check("gaps_last", hs_last[h0 + 2], 1);
    tick();
    check("gaps_ignored_start", busy, 0);

    // num_samples = 0
    h0 = hs_cnt;
    d0 = done_cnt;
    start_run(0);
    s_cyc = cyc;
    for (int i = 0; i < 3 && done_cnt == d0; i++) tick();
    check("n0_done", done_cnt, d0 + 1);
    check("n0_done_latency_ok", (done_cyc - s_cyc) <= 2, 1);
    tick();
    check("n0_no_words", hs_cnt - h0, 0);

    // LATENCY = 0 instance: first valid sample lands in bit 0
    num_samples = 16'd3;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    send(1'b1); send(1'b0); send(1'b0);
    seen0 = 1'b0;
    for (int i = 0; i < 10 && !seen0; i++) begin
      if (m_valid0) begin
        seen0 = 1'b1;
        check("lat0_data", m_data0, 32'h00000001);
        check("lat0_last", m_last0, 1);
      end else begin
        tick();
      end
    end
    check("lat0_word_seen", seen0, 1);
    seen0 = 1'b0;
    for (int i = 0; i < 10 && !seen0; i++) begin
      if (done0) seen0 = 1'b1;
      else tick();
    end
    check("lat0_done", seen0, 1);
    tick();
    check("lat0_idle", {busy0, overflow0}, 0);

    // Reset mid-CAPTURE, then a clean run
    d0 = done_cnt;
    start_run(64);
    flush_fill();
    for (int k = 0; k < 10; k++) send(1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("abort_no_done", done_cnt, d0);
    check("abort_idle", {busy, m_valid}, 0);
    h0 = hs_cnt;
    bits5 = 5'b10011;
    start_run(5);
    flush_fill();
    for (int k = 0; k < 5; k++) send(bits5[k]);
    wait_done(20, "after_abort_done");
    check("after_abort_words", hs_cnt - h0, 1);
    check("after_abort_data", hs_data[h0], 32'h00000013);

    for (int i = 0; i < 3; i++) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
